operand_sweep_gen: RTL and testbench
====================================

// Module: operand_sweep_gen
//
// PURPOSE
//   Sequential operand source for the 8-bit XOR/OR comparison unit.
//   On a start pulse it walks every (a,b) pair, a = 0..A_MAX outer and b = 0..B_MAX inner,
//   and presents one pair per accepted transfer on a valid/ready interface.
//   It replaces the testbench nested for-loop with synthesizable hardware that sits directly
//   upstream of the XOR/OR unit's a/b inputs.
//
// PARAMETERS
//   WIDTH   8   operand width in bits (a, b)
//   A_MAX   7   last value of outer operand a; 0 <= A_MAX <= 2**WIDTH-1
//   B_MAX   7   last value of inner operand b; 0 <= B_MAX <= 2**WIDTH-1
//   CNT_W   $clog2((A_MAX+1)*(B_MAX+1)+1)   width of pair index, derived, do not override
//
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-high reset
//   start      in   1      1-cycle request to begin a sweep; honoured only in IDLE
//   abort      in   1      synchronous abort; ends the sweep without a done pulse
//   out_valid  out  1      a/b/idx/last hold a pair
//   out_ready  in   1      consumer accepts the pair this cycle
//   a          out  WIDTH  outer operand
//   b          out  WIDTH  inner operand
//   idx        out  CNT_W  ordinal of the current pair: a*(B_MAX+1)+b
//   last       out  1      current pair is (A_MAX,B_MAX); valid only with out_valid
//   busy       out  1      FSM is not in IDLE
//   done       out  1      1-cycle pulse after the final pair is accepted
//
// BEHAVIOUR
//   Reset (async, reset=1):
//     - FSM goes to IDLE.
//     - out_valid, a, b, idx, last, busy and done are all 0.
//   FSM states: IDLE -> RUN -> DONE -> IDLE; transitions are registered.
//   IDLE:
//     - start=1 sets a=0, b=0, idx=0, out_valid=1 and enters RUN.
//     - The first pair is visible on the cycle after start (1-cycle latency).
//     - busy=1 from that same cycle.
//   RUN, transfer (out_valid & out_ready):
//     - Not last: if b==B_MAX then b<=0 and a<=a+1, else b<=b+1. idx<=idx+1.
//       out_valid stays 1, so back-to-back transfers give one pair per cycle.
//     - last=1: out_valid<=0 and the FSM enters DONE.
//   RUN, stall (out_valid & ~out_ready): a, b, idx, last and out_valid hold stable.
//     The producer never withdraws or changes a pair that has not been accepted.
//   last output: combinational decode (a==A_MAX && b==B_MAX) gated by out_valid.
//   DONE: done=1 for exactly one cycle, then IDLE.
//     - busy=1 in DONE and falls in the following cycle.
//     - a, b and idx keep their final values until the next start.
//   Degenerate A_MAX=B_MAX=0: exactly one pair (0,0) with last=1, then done.
//   start while busy: ignored with no restart and no side effect.
//   abort=1 in RUN or DONE: the next state is IDLE.
//     - out_valid<=0; done is not pulsed (suppressed if it coincides with DONE).
//     - abort has priority over a same-cycle transfer, but the consumer still sees that
//       cycle's handshake, so that one pair counts as delivered.
//     - a, b and idx are cleared to 0.
//   start and abort together in IDLE: abort wins; stay IDLE.
//   Arithmetic: a and b never exceed A_MAX/B_MAX, so no WIDTH wrap occurs.
//     With A_MAX=2**WIDTH-1, the increment of a is never taken past the last pair.
//   Reset mid-sweep: all state clears immediately; a new start is needed.
//   Total transfers per full sweep: (A_MAX+1)*(B_MAX+1); defaults give 64.
//
// TESTING
//   1. Defaults, out_ready=1, start pulse -> 64 consecutive valid cycles.
//      Pairs run (0,0),(0,1)..(0,7),(1,0)..(7,7); idx runs 0..63.
//      last=1 only on (7,7); done pulses one cycle after; busy=0 the cycle after that.
//   2. out_ready toggling 1,0,0,1 per cycle -> a/b/idx frozen during 0 cycles.
//      Still exactly 64 unique pairs accepted, in order, with no duplicates.
//   3. Row wrap: accept (2,7) -> the next pair is (3,0) with idx=24.
//      Compare the XOR/OR unit's outputs to a^b per pair.
//   4. abort on the cycle idx=10 is presented with out_ready=0 ->
//      out_valid=0 next cycle, no done, a=b=idx=0. A new start restarts at (0,0).
//   5. start held 1 for 5 cycles mid-RUN -> sweep unaffected, still ends at (7,7) with one done.
//   6. Assert reset mid-sweep at (4,3) -> all outputs 0 asynchronously.
//      A_MAX=B_MAX=0 build: start gives a single (0,0) with last=1, then done.

Source files
------------

// File: rtl/operand_sweep_gen.sv
// rtl/operand_sweep_gen.sv - sequential (a,b) operand sweep source on a valid/ready interface
module operand_sweep_gen #(
    parameter int WIDTH = 8,
    parameter int A_MAX = 7,
    parameter int B_MAX = 7,
    parameter int CNT_W = $clog2((A_MAX + 1) * (B_MAX + 1) + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [CNT_W-1:0] idx,
    output logic             last,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] DONE_ST = 2'd2;

    localparam logic [WIDTH-1:0] A_LAST = WIDTH'(A_MAX);
    localparam logic [WIDTH-1:0] B_LAST = WIDTH'(B_MAX);

    logic [1:0] state;
    logic       pair_last;
    logic       xfer;

    assign pair_last = (a == A_LAST) && (b == B_LAST);
    assign xfer      = out_valid && out_ready;
    assign last      = out_valid && pair_last;
    assign busy      = (state != IDLE);
    // An abort landing on the DONE cycle swallows the pulse.
    assign done      = (state == DONE_ST) && !abort;

    // Sweep FSM and operand counters; a stalled pair is held untouched until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state     <= RUN;
                        a         <= '0;
                        b         <= '0;
                        idx       <= '0;
                        out_valid <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        a         <= '0;
                        b         <= '0;
                        idx       <= '0;
                    end else if (xfer) begin
                        if (pair_last) begin
                            // Final pair taken: counters keep their last values for inspection.
                            out_valid <= 1'b0;
                            state     <= DONE_ST;
                        end else begin
                            idx <= idx + CNT_W'(1);
                            if (b == B_LAST) begin
                                b <= '0;
                                a <= a + WIDTH'(1);
                            end else begin
                                b <= b + WIDTH'(1);
                            end
                        end
                    end
                end
                DONE_ST: begin
                    state <= IDLE;
                    if (abort) begin
                        a   <= '0;
                        b   <= '0;
                        idx <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_sweep_gen.sv
// tb/tb_operand_sweep_gen.sv - directed self-checking bench for operand_sweep_gen
module tb_operand_sweep_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       start, abort, out_ready;
    logic       out_valid, last, busy, done;
    logic [7:0] a, b;
    logic [6:0] idx;

    logic       d_start, d_abort, d_ready;
    logic       d_valid, d_last, d_busy, d_done;
    logic [7:0] d_a, d_b;
    logic [0:0] d_idx;

    int compared   = 0;
    int mismatched = 0;

    operand_sweep_gen dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .idx(idx), .last(last), .busy(busy), .done(done)
    );

    operand_sweep_gen #(.WIDTH(8), .A_MAX(0), .B_MAX(0)) dut0 (
        .clk(clk), .reset(reset), .start(d_start), .abort(d_abort),
        .out_valid(d_valid), .out_ready(d_ready),
        .a(d_a), .b(d_b), .idx(d_idx), .last(d_last), .busy(d_busy), .done(d_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_pair(input string tag, input int k, input logic exp_last);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_a"},     32'(a),         32'(k / 8));
        chk({tag, "_b"},     32'(b),         32'(k % 8));
        chk({tag, "_idx"},   32'(idx),       32'(k));
        chk({tag, "_last"},  32'(last),      32'(exp_last));
        chk({tag, "_busy"},  32'(busy),      32'd1);
    endtask

    task automatic chk_final(input string tag);
        chk({tag, "_done"},  32'(done),      32'd1);
        chk({tag, "_busyD"}, 32'(busy),      32'd1);
        chk({tag, "_vD"},    32'(out_valid), 32'd0);
        tick();
        chk({tag, "_done0"}, 32'(done),      32'd0);
        chk({tag, "_busy0"}, 32'(busy),      32'd0);
        chk({tag, "_holdA"}, 32'(a),         32'd7);
        chk({tag, "_holdB"}, 32'(b),         32'd7);
        chk({tag, "_holdI"}, 32'(idx),       32'd63);
    endtask

    initial begin
        int k;
        int cyc;
        int dones;
        logic [3:0] pat;

        reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        d_start = 1'b0; d_abort = 1'b0; d_ready = 1'b1;
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a",     32'(a),         32'd0);
        chk("rst_b",     32'(b),         32'd0);
        chk("rst_idx",   32'(idx),       32'd0);
        chk("rst_last",  32'(last),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // full sweep, consumer always ready
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk_pair("t1", i, i == 63);
            tick();
        end
        chk_final("t1");

        // ready pattern 1,0,0,1: stalls must freeze the pair
        pat = 4'b1001;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = 0;
        cyc = 0;
        while (k < 64 && cyc < 400) begin
            out_ready = pat[3 - (cyc % 4)];
            chk_pair("t2", k, k == 63);
            chk("t2_xor", 32'(a ^ b), 32'((k / 8) ^ (k % 8)));
            tick();
            if (out_ready) k++;
            cyc++;
        end
        chk("t2_count", 32'(k), 32'd64);
        chk_final("t2");

        // abort while idx=10 is stalled
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk_pair("t4_pre", 10, 1'b0);
        out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("t4_valid", 32'(out_valid), 32'd0);
        chk("t4_done",  32'(done),      32'd0);
        chk("t4_busy",  32'(busy),      32'd0);
        chk("t4_a",     32'(a),         32'd0);
        chk("t4_b",     32'(b),         32'd0);
        chk("t4_idx",   32'(idx),       32'd0);
        tick();
        chk("t4_done2", 32'(done),      32'd0);
        chk("t4_valid2", 32'(out_valid), 32'd0);

        // start+abort in IDLE: stay idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy",  32'(busy),      32'd0);
        chk("sa_valid", 32'(out_valid), 32'd0);

        // restart, with start held high mid-run
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 64; i++) begin
            start = (i >= 20 && i < 25);
            chk_pair("t5", i, i == 63);
            tick();
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) dones++;
            tick();
        end
        chk("t5_dones", 32'(dones), 32'd1);
        chk("t5_idle",  32'(busy),  32'd0);

        // async reset at (4,3)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 35; i++) tick();
        chk_pair("t6_pre", 35, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_a",     32'(a),         32'd0);
        chk("t6_b",     32'(b),         32'd0);
        chk("t6_idx",   32'(idx),       32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_done",  32'(done),      32'd0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("t6_nostart", 32'(out_valid), 32'd0);

        // degenerate single-pair build
        d_start = 1'b1;
        tick();
        d_start = 1'b0;
        chk("d_valid", 32'(d_valid), 32'd1);
        chk("d_a",     32'(d_a),     32'd0);
        chk("d_b",     32'(d_b),     32'd0);
        chk("d_idx",   32'(d_idx),   32'd0);
        chk("d_last",  32'(d_last),  32'd1);
        chk("d_busy",  32'(d_busy),  32'd1);
        tick();
        chk("d_valid2", 32'(d_valid), 32'd0);
        chk("d_done",   32'(d_done),  32'd1);
        tick();
        chk("d_done2",  32'(d_done),  32'd0);
        chk("d_busy2",  32'(d_busy),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
